// File: rtl/router_port_receiver.sv
// Router output-port consumer: drains the FIFO of one router port, re-frames each
// packet as a strobed byte stream with SOP/EOP, and checks parity, address and stalls.
module router_port_receiver #(
   parameter logic [1:0]  PORT_ID = 2'd0,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        valid_out,
   input  logic [7:0]  data_out,
   output logic        read_enb,
   output logic [7:0]  pkt_byte,
   output logic        byte_valid,
   output logic        sop,
   output logic        eop,
   output logic [5:0]  pkt_len,
   output logic        pkt_done,
   output logic        parity_err,
   output logic        addr_err,
   output logic        timeout_err,
   output logic [15:0] pkt_count
);

   // Abort is decided one cycle early so pkt_done lands in the TIMEOUT-th stalled cycle.
   localparam logic [7:0] StallLast = 8'(TIMEOUT - 2);

   typedef enum logic [2:0] {StIdle, StHdr, StPayload, StParity, StDone} state_e;

   state_e      state_q, state_d;
   logic        rd_pend_q, rd_pend_d;
   logic [7:0]  stall_q, stall_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [7:0]  par_q, par_d;
   logic [1:0]  addr_q, addr_d;
   logic [7:0]  byte_q, byte_d;
   logic        bv_q, bv_d;
   logic        sop_q, sop_d;
   logic        eop_q, eop_d;
   logic [5:0]  len_q, len_d;
   logic        done_q, done_d;
   logic        perr_q, perr_d;
   logic        aerr_q, aerr_d;
   logic        terr_q, terr_d;
   logic [15:0] count_q, count_d;

   logic        in_pkt;
   logic        hdr_take;

   assign read_enb = valid_out & resetn & (state_q != StDone);

   assign in_pkt = (state_q == StHdr) || (state_q == StPayload) || (state_q == StParity);
   // A read issued in the parity cycle returns the next header while in DONE.
   assign hdr_take = rd_pend_q && ((state_q == StHdr) || (state_q == StDone));

   // Next-state, byte framing, checking and stall-timer logic.
   always_comb begin
      state_d   = state_q;
      rd_pend_d = read_enb;
      stall_d   = 8'd0;
      cnt_d     = cnt_q;
      par_d     = par_q;
      addr_d    = addr_q;
      byte_d    = byte_q;
      bv_d      = 1'b0;
      sop_d     = 1'b0;
      eop_d     = 1'b0;
      len_d     = len_q;
      done_d    = 1'b0;
      perr_d    = perr_q;
      aerr_d    = aerr_q;
      terr_d    = terr_q;
      count_d   = count_q;

      unique case (state_q)
         StIdle: begin
            if (read_enb) state_d = StHdr;
         end
         StHdr: ;
         StPayload: begin
            if (rd_pend_q) begin
               par_d  = par_q ^ data_out;
               byte_d = data_out;
               bv_d   = 1'b1;
               eop_d  = (cnt_q == 6'd1);
               cnt_d  = cnt_q - 6'd1;
               if (cnt_q == 6'd1) state_d = StParity;
            end
         end
         StParity: begin
            if (rd_pend_q) begin
               perr_d  = (data_out != par_q);
               aerr_d  = (addr_q != PORT_ID);
               done_d  = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            if (!perr_q && !aerr_q && !terr_q) count_d = count_q + 16'd1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (hdr_take) begin
         len_d   = data_out[7:2];
         addr_d  = data_out[1:0];
         par_d   = data_out;
         byte_d  = data_out;
         bv_d    = 1'b1;
         sop_d   = 1'b1;
         eop_d   = (data_out[7:2] == 6'd0);
         cnt_d   = data_out[7:2];
         perr_d  = 1'b0;
         aerr_d  = 1'b0;
         terr_d  = 1'b0;
         state_d = (data_out[7:2] == 6'd0) ? StParity : StPayload;
      end

      if (in_pkt && !valid_out && !rd_pend_q) begin
         if (stall_q == StallLast) begin
            terr_d    = 1'b1;
            done_d    = 1'b1;
            rd_pend_d = 1'b0;
            state_d   = StIdle;
         end else begin
            stall_d = stall_q + 8'd1;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q   <= StIdle;
         rd_pend_q <= 1'b0;
         stall_q   <= 8'd0;
         cnt_q     <= 6'd0;
         par_q     <= 8'd0;
         addr_q    <= 2'd0;
         byte_q    <= 8'd0;
         bv_q      <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         len_q     <= 6'd0;
         done_q    <= 1'b0;
         perr_q    <= 1'b0;
         aerr_q    <= 1'b0;
         terr_q    <= 1'b0;
         count_q   <= 16'd0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_pend_d;
         stall_q   <= stall_d;
         cnt_q     <= cnt_d;
         par_q     <= par_d;
         addr_q    <= addr_d;
         byte_q    <= byte_d;
         bv_q      <= bv_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         len_q     <= len_d;
         done_q    <= done_d;
         perr_q    <= perr_d;
         aerr_q    <= aerr_d;
         terr_q    <= terr_d;
         count_q   <= count_d;
      end
   end

   assign pkt_byte    = byte_q;
   assign byte_valid  = bv_q;
   assign sop         = sop_q;
   assign eop         = eop_q;
   assign pkt_len     = len_q;
   assign pkt_done    = done_q;
   assign parity_err  = perr_q;
   assign addr_err    = aerr_q;
   assign timeout_err = terr_q;
   assign pkt_count   = count_q;

endmodule

// File: tb/tb_router_port_receiver.sv
// Scoreboard bench for router_port_receiver: a FIFO model feeds packets, expected
// strobes and packet-close records are queued at issue and checked by a monitor.
module tb_router_port_receiver;

   localparam logic [1:0]  PortId  = 2'd2;
   localparam int unsigned Timeout = 16;

   logic        clock;
   logic        resetn;
   logic        valid_out;
   logic [7:0]  data_out;
   logic        read_enb;
   logic [7:0]  pkt_byte;
   logic        byte_valid;
   logic        sop;
   logic        eop;
   logic [5:0]  pkt_len;
   logic        pkt_done;
   logic        parity_err;
   logic        addr_err;
   logic        timeout_err;
   logic [15:0] pkt_count;

   router_port_receiver #(
      .PORT_ID (PortId),
      .TIMEOUT (Timeout)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .valid_out   (valid_out),
      .data_out    (data_out),
      .read_enb    (read_enb),
      .pkt_byte    (pkt_byte),
      .byte_valid  (byte_valid),
      .sop         (sop),
      .eop         (eop),
      .pkt_len     (pkt_len),
      .pkt_done    (pkt_done),
      .parity_err  (parity_err),
      .addr_err    (addr_err),
      .timeout_err (timeout_err),
      .pkt_count   (pkt_count)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0] fifo [$];
   logic [9:0] exp_q [$];   // {byte, sop, eop}
   logic [8:0] done_q [$];  // {parity_err, addr_err, timeout_err, pkt_len}
   logic [7:0] pay [0:7];

   int   cyc = 0;
   int   strobes = 0;
   int   last_byte_cyc = 0;
   int   last_done_cyc = 0;
   logic tog = 1'b0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare every strobe and every packet close against the scoreboard.
   initial begin
      logic [9:0] e;
      logic [8:0] d;
      forever begin
         @(negedge clock);
         cyc++;
         if (resetn) begin
            if (read_enb) check("read_enb_without_valid", {31'd0, valid_out}, 32'd1);
            if (byte_valid) begin
               strobes++;
               last_byte_cyc = cyc;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_strobe: got %0h expected none", {pkt_byte, sop, eop});
               end else begin
                  checks--;
                  e = exp_q.pop_front();
                  check("strobe", {22'd0, pkt_byte, sop, eop}, {22'd0, e});
               end
               if (sop) check("flags_clear_at_sop", {29'd0, parity_err, addr_err, timeout_err}, 32'd0);
            end
            if (pkt_done) begin
               last_done_cyc = cyc;
               checks++;
               if (done_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done: got %0h expected none",
                           {parity_err, addr_err, timeout_err, pkt_len});
               end else begin
                  checks--;
                  d = done_q.pop_front();
                  check("pkt_done_record", {23'd0, parity_err, addr_err, timeout_err, pkt_len},
                        {23'd0, d});
               end
            end
         end
      end
   end

   // One clock of the router FIFO model: a read in this cycle returns data next cycle.
   task automatic step(input int mode);
      logic re;
      @(negedge clock);
      re = read_enb;
      @(posedge clock);
      #1;
      if (re) begin
         if (fifo.size() > 0) data_out = fifo.pop_front();
         else begin
            checks++;
            errors++;
            $display("FAIL fifo_underflow: got read expected none");
         end
      end
      tog = ~tog;
      valid_out = (fifo.size() > 0) && (mode == 0 || tog);
   endtask

   task automatic send_pkt(input logic [7:0] hdr, input int n_sent, input logic [7:0] par_xor,
                           input logic [2:0] exp_err);
      logic [7:0] par;
      int len;
      len = int'(hdr[7:2]);
      par = hdr;
      fifo.push_back(hdr);
      exp_q.push_back({hdr, 1'b1, len == 0});
      for (int i = 0; i < n_sent; i++) begin
         fifo.push_back(pay[i]);
         par ^= pay[i];
         exp_q.push_back({pay[i], 1'b0, i == len - 1});
      end
      if (n_sent == len) fifo.push_back(par ^ par_xor);
      done_q.push_back({exp_err, hdr[7:2]});
   endtask

   task automatic run(input int mode, input int max_cyc);
      int n;
      n = 0;
      while ((fifo.size() != 0 || exp_q.size() != 0 || done_q.size() != 0) && n < max_cyc) begin
         step(mode);
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         errors++;
         $display("FAIL drain_bound: got %0d cycles expected < %0d", n, max_cyc);
      end
      repeat (4) step(mode);
   endtask

   task automatic set_pay(input logic [63:0] v);
      for (int i = 0; i < 8; i++) pay[i] = v[63 - 8*i -: 8];
   endtask

   initial begin
      int n;
      int s0;
      resetn    = 1'b0;
      valid_out = 1'b1;
      data_out  = 8'h00;
      repeat (3) @(negedge clock);
      check("rst_read_enb", {31'd0, read_enb}, 32'd0);
      check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
      check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
      check("rst_flags", {26'd0, sop, eop, parity_err, addr_err, timeout_err}, 32'd0);
      check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
      check("rst_pkt_len_byte", {18'd0, pkt_len, pkt_byte}, 32'd0);
      @(posedge clock);
      #1;
      valid_out = 1'b0;
      resetn    = 1'b1;
      repeat (3) step(0);

      // Clean len-8 packet to port 2.
      set_pay(64'hA5_3C_0F_F0_11_22_81_7E);
      send_pkt(8'h22, 8, 8'h00, 3'b000);
      run(0, 100);
      check("good_count", {16'd0, pkt_count}, 32'd1);
      check("good_len", {26'd0, pkt_len}, 32'd8);

      // Parity error, flag held across idle cycles.
      set_pay(64'h01_02_03_04_05_00_00_00);
      send_pkt(8'h16, 5, 8'h01, 3'b100);
      run(0, 100);
      repeat (5) step(0);
      check("perr_held", {31'd0, parity_err}, 32'd1);
      check("perr_count", {16'd0, pkt_count}, 32'd1);

      // Good packet then, back-to-back, a wrong-address packet still fully drained.
      set_pay(64'hA5_3C_0F_F0_11_22_81_7E);
      send_pkt(8'h22, 8, 8'h00, 3'b000);
      set_pay(64'h10_20_30_40_50_60_70_80);
      send_pkt(8'h21, 8, 8'h00, 3'b010);
      run(0, 100);
      check("aerr_held", {31'd0, addr_err}, 32'd1);
      check("aerr_count", {16'd0, pkt_count}, 32'd2);

      // Stall abort after header + 1 of 3 payload bytes.
      set_pay(64'h5A_00_00_00_00_00_00_00);
      send_pkt(8'h0E, 1, 8'h00, 3'b001);
      run(0, 100);
      check("timeout_latency", last_done_cyc - last_byte_cyc, Timeout - 1);
      repeat (40) step(0);
      check("terr_held", {31'd0, timeout_err}, 32'd1);
      check("terr_len", {26'd0, pkt_len}, 32'd3);
      check("terr_count", {16'd0, pkt_count}, 32'd2);

      set_pay(64'hA5_3C_0F_F0_11_22_81_7E);
      send_pkt(8'h22, 8, 8'h00, 3'b000);
      run(0, 100);
      check("after_timeout_count", {16'd0, pkt_count}, 32'd3);

      // valid_out toggling every cycle.
      set_pay(64'hDE_AD_BE_EF_00_FF_55_AA);
      send_pkt(8'h22, 8, 8'h00, 3'b000);
      run(1, 100);
      check("toggle_count", {16'd0, pkt_count}, 32'd4);

      // Reset after the 4th payload strobe.
      set_pay(64'hA5_3C_0F_F0_11_22_81_7E);
      send_pkt(8'h22, 8, 8'h00, 3'b000);
      s0 = strobes;
      n  = 0;
      while (strobes < s0 + 5 && n < 60) begin
         step(0);
         n++;
      end
      check("reset_point_reached", {31'd0, n < 60}, 32'd1);
      resetn    = 1'b0;
      fifo.delete();
      valid_out = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      exp_q.delete();
      done_q.delete();
      @(negedge clock);
      check("mid_rst_outputs",
            {15'd0, byte_valid, sop, eop, pkt_done, parity_err, addr_err, timeout_err, pkt_byte},
            32'd0);
      check("mid_rst_count_len", {10'd0, pkt_count, pkt_len}, 32'd0);
      send_pkt(8'h22, 8, 8'h00, 3'b000);
      run(0, 100);
      check("post_rst_count", {16'd0, pkt_count}, 32'd1);

      // Zero-length packet: header carries both sop and eop.
      send_pkt(8'h02, 0, 8'h00, 3'b000);
      run(0, 100);
      check("len0_count", {16'd0, pkt_count}, 32'd2);

      // Parity byte of 8'h00 is legal.
      set_pay(64'h06_00_00_00_00_00_00_00);
      send_pkt(8'h06, 1, 8'h00, 3'b000);
      run(0, 100);
      check("par00_count", {16'd0, pkt_count}, 32'd3);
      check("par00_perr", {31'd0, parity_err}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
